// File: rtl/ffe_pkg.sv
// rtl/ffe_pkg.sv - shared constants and state encoding for the FFE coefficient config slice
package ffe_pkg;

  localparam int FFE_COEFF_WIDTH = 12;
  localparam int FFE_NUM_TAPS    = 4;

  // Config controller states (2-bit, legacy-compatible encoding)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_COPY = 2'd2;

  // Unity gain in Q2.(W-2) at the default width
  localparam logic [FFE_COEFF_WIDTH-1:0] COEFF_UNITY = 12'h400;

  // Unity gain in Q2.(w-2) for an arbitrary coefficient width
  function automatic int unsigned unity_for_width(input int unsigned w);
    return 32'd1 << (w - 32'd2);
  endfunction

endpackage

// File: rtl/ffe_cfg_if.sv
// rtl/ffe_cfg_if.sv - coefficient write / commit request bus
interface ffe_cfg_if #(
  parameter int CFG_ADDR_WIDTH = 3,
  parameter int COEFF_WIDTH    = 12
);

  logic                             cfg_valid;
  logic                             cfg_ready;
  logic        [CFG_ADDR_WIDTH-1:0] cfg_addr;
  logic signed [COEFF_WIDTH-1:0]    cfg_data;
  logic                             cfg_commit;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  cfg_commit,
    output cfg_ready
  );

endinterface

// File: rtl/ffe_coeff_bank.sv
// rtl/ffe_coeff_bank.sv - double-buffered tap coefficient storage with active read port
module ffe_coeff_bank
  import ffe_pkg::*;
#(
  parameter int COEFF_WIDTH   = FFE_COEFF_WIDTH,
  parameter int NUM_TAPS      = FFE_NUM_TAPS,
  parameter int RD_ADDR_WIDTH = 2,
  parameter logic [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(COEFF_UNITY)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic        [RD_ADDR_WIDTH-1:0] wr_addr,
  input  logic        [COEFF_WIDTH-1:0]   wr_data,
  input  logic                            cp_en,
  input  logic        [RD_ADDR_WIDTH-1:0] cp_addr,
  input  logic                            toggle,
  input  logic        [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic signed [COEFF_WIDTH-1:0]   rd_data,
  output logic                            bank_sel
);

  logic [COEFF_WIDTH-1:0] bank_q [2][NUM_TAPS];
  logic [COEFF_WIDTH-1:0] bank_d [2][NUM_TAPS];
  logic                   sel_q;
  logic                   sel_d;

  // Shadow bank is always the one not selected; writes and copies only touch it
  always_comb begin
    bank_d = bank_q;
    sel_d  = sel_q;
    if (wr_en) begin
      bank_d[~sel_q][wr_addr] = wr_data;
    end
    if (cp_en) begin
      bank_d[~sel_q][cp_addr] = bank_q[sel_q][cp_addr];
    end
    if (toggle) begin
      sel_d = ~sel_q;
    end
  end

  // Both banks reset to a pass-through filter (unity on tap 0)
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
          bank_q[b][t] <= (t == 0) ? UNITY : '0;
        end
      end
    end else begin
      sel_q  <= sel_d;
      bank_q <= bank_d;
    end
  end

  assign rd_data  = bank_q[sel_q][rd_addr];
  assign bank_sel = sel_q;

endmodule

// File: rtl/ffe_coeff_cfg.sv
// rtl/ffe_coeff_cfg.sv - FFE tap config controller: shadow writes, sample-aligned swap, re-sync copy
module ffe_coeff_cfg
  import ffe_pkg::*;
#(
  parameter int COEFF_WIDTH    = FFE_COEFF_WIDTH,
  parameter int NUM_TAPS       = FFE_NUM_TAPS,
  parameter int CFG_ADDR_WIDTH = 3,
  parameter int RD_ADDR_WIDTH  = 2
) (
  input  logic                            ffe_clk,
  input  logic                            rst,
  ffe_cfg_if.slave                        cfg,
  input  logic                            sample_done,
  input  logic        [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic signed [COEFF_WIDTH-1:0]   coeff,
  output logic                            active_bank,
  output logic                            commit_done,
  output logic                            cfg_err
);

  localparam logic [CFG_ADDR_WIDTH-1:0] TAPS_LIM = CFG_ADDR_WIDTH'(NUM_TAPS);
  localparam logic [RD_ADDR_WIDTH-1:0]  LAST_TAP = RD_ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [COEFF_WIDTH-1:0]    UNITY    = COEFF_WIDTH'(unity_for_width(COEFF_WIDTH));

  logic [1:0]               state_q, state_d;
  logic [RD_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     done_q, done_d;
  logic                     ready_q, ready_d;

  logic                     hs;
  logic                     addr_ok;
  logic                     wr_en;
  logic                     cp_en;
  logic                     toggle;

  // Next-state logic: writes land in IDLE, swap waits for a sample boundary, then re-sync
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    cp_en   = 1'b0;
    toggle  = 1'b0;
    hs      = cfg.cfg_valid & ready_q;
    addr_ok = (cfg.cfg_addr < TAPS_LIM);
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (addr_ok) begin
            wr_en = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        // The commit clears the error even if this cycle's write was out of range
        if (cfg.cfg_commit) begin
          state_d = ST_PEND;
          err_d   = 1'b0;
        end
      end
      ST_PEND: begin
        if (sample_done) begin
          toggle  = 1'b1;
          state_d = ST_COPY;
          cnt_d   = '0;
        end
      end
      ST_COPY: begin
        cp_en = 1'b1;
        if (cnt_q == LAST_TAP) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Controller registers; reset abandons any pending commit without a done pulse
  always_ff @(posedge ffe_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  ffe_coeff_bank #(
    .COEFF_WIDTH   (COEFF_WIDTH),
    .NUM_TAPS      (NUM_TAPS),
    .RD_ADDR_WIDTH (RD_ADDR_WIDTH),
    .UNITY         (UNITY)
  ) u_bank (
    .clk      (ffe_clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (cfg.cfg_addr[RD_ADDR_WIDTH-1:0]),
    .wr_data  (cfg.cfg_data),
    .cp_en    (cp_en),
    .cp_addr  (cnt_q),
    .toggle   (toggle),
    .rd_addr  (rd_addr),
    .rd_data  (coeff),
    .bank_sel (active_bank)
  );

  assign cfg.cfg_ready = ready_q;
  assign commit_done   = done_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_ffe_coeff_cfg.sv
// tb/tb_ffe_coeff_cfg.sv - scoreboard bench for the FFE coefficient config controller
module tb_ffe_coeff_cfg;

  logic               ffe_clk;
  logic               rst;
  logic               sample_done;
  logic        [1:0]  rd_addr;
  logic signed [11:0] coeff;
  logic               active_bank;
  logic               commit_done;
  logic               cfg_err;

  ffe_cfg_if #(.CFG_ADDR_WIDTH(3), .COEFF_WIDTH(12)) cfg_bus ();

  ffe_coeff_cfg #(
    .COEFF_WIDTH    (12),
    .NUM_TAPS       (4),
    .CFG_ADDR_WIDTH (3),
    .RD_ADDR_WIDTH  (2)
  ) dut (
    .ffe_clk     (ffe_clk),
    .rst         (rst),
    .cfg         (cfg_bus),
    .sample_done (sample_done),
    .rd_addr     (rd_addr),
    .coeff       (coeff),
    .active_bank (active_bank),
    .commit_done (commit_done),
    .cfg_err     (cfg_err)
  );

  initial ffe_clk = 1'b0;
  always #10 ffe_clk = ~ffe_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] sh [4];
  logic [11:0] exp_q [$];

  task automatic tick();
    @(posedge ffe_clk);
    #1;
  endtask

  task automatic model_reset();
    sh[0] = 12'h400; sh[1] = 12'h000; sh[2] = 12'h000; sh[3] = 12'h000;
    exp_q.delete();
  endtask

  task automatic drive_write(input logic [2:0] a, input logic [11:0] d);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = a;
    cfg_bus.cfg_data  = d;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    if (a < 3'd4) sh[a[1:0]] = d;
  endtask

  task automatic push_snapshot();
    for (int i = 0; i < 4; i++) exp_q.push_back(sh[i]);
  endtask

  task automatic commit_pulse();
    cfg_bus.cfg_commit = 1'b1;
    tick();
    cfg_bus.cfg_commit = 1'b0;
    push_snapshot();
  endtask

  task automatic pulse_sample();
    sample_done = 1'b1;
    tick();
    sample_done = 1'b0;
  endtask

  task automatic wait_done(input int start, output int n);
    n = start;
    while (commit_done !== 1'b1 && n < 32) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [11:0] rexp [4];
    rexp[0] = 12'h400; rexp[1] = 12'h000; rexp[2] = 12'h000; rexp[3] = 12'h000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      n_cmp++;
      if (coeff !== rexp[i]) begin
        n_bad++;
        $display("FAIL reset_coeff tap%0d got %h want %h", i, coeff, rexp[i]);
      end
    end
    n_cmp++;
    if (active_bank !== 1'b0) begin n_bad++; $display("FAIL reset_bank got %b want 0", active_bank); end
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", cfg_bus.cfg_ready); end
    n_cmp++;
    if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", cfg_err); end
    n_cmp++;
    if (commit_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", commit_done); end
  endtask

  task automatic test_basic_commit();
    int n;
    logic [11:0] e;
    drive_write(3'd0, 12'h200);
    drive_write(3'd1, 12'hF00);
    drive_write(3'd2, 12'h080);
    drive_write(3'd3, 12'h000);
    commit_pulse();
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL basic_pend_ready got %b want 0", cfg_bus.cfg_ready); end
    tick();
    tick();
    sample_done = 1'b1;
    rd_addr = 2'd0;
    #1;
    n_cmp++;
    if (coeff !== 12'h400) begin n_bad++; $display("FAIL basic_pre_swap got %h want 400", coeff); end
    n_cmp++;
    if (active_bank !== 1'b0) begin n_bad++; $display("FAIL basic_pre_bank got %b want 0", active_bank); end
    tick();
    sample_done = 1'b0;
    n_cmp++;
    if (active_bank !== 1'b1) begin n_bad++; $display("FAIL basic_post_bank got %b want 1", active_bank); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (coeff !== e) begin n_bad++; $display("FAIL basic_coeff tap%0d got %h want %h", i, coeff, e); end
    end
    wait_done(1, n);
    n_cmp++;
    if (n !== 5) begin n_bad++; $display("FAIL basic_latency got %0d want 5", n); end
    tick();
    n_cmp++;
    if (commit_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", commit_done); end
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL basic_idle_ready got %b want 1", cfg_bus.cfg_ready); end
  endtask

  task automatic test_same_cycle_commit();
    int n;
    logic [11:0] e;
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_addr   = 3'd2;
    cfg_bus.cfg_data   = 12'h123;
    cfg_bus.cfg_commit = 1'b1;
    sample_done        = 1'b1;
    tick();
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_commit = 1'b0;
    sample_done        = 1'b0;
    sh[2] = 12'h123;
    push_snapshot();
    rd_addr = 2'd2;
    #1;
    n_cmp++;
    if (active_bank !== 1'b1) begin n_bad++; $display("FAIL same_no_swap_bank got %b want 1", active_bank); end
    n_cmp++;
    if (coeff !== 12'h080) begin n_bad++; $display("FAIL same_no_swap_coeff got %h want 080", coeff); end
    tick();
    n_cmp++;
    if (active_bank !== 1'b1) begin n_bad++; $display("FAIL same_still_pend got %b want 1", active_bank); end
    pulse_sample();
    n_cmp++;
    if (active_bank !== 1'b0) begin n_bad++; $display("FAIL same_swap_bank got %b want 0", active_bank); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (coeff !== e) begin n_bad++; $display("FAIL same_coeff tap%0d got %h want %h", i, coeff, e); end
    end
    wait_done(1, n);
    n_cmp++;
    if (n !== 5) begin n_bad++; $display("FAIL same_latency got %0d want 5", n); end
    tick();
  endtask

  task automatic test_held_write();
    int n;
    logic [11:0] e;
    commit_pulse();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = 3'd1;
    cfg_bus.cfg_data  = 12'h055;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (cfg_bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL held_pend_ready c%0d got %b want 0", k, cfg_bus.cfg_ready); end
      tick();
    end
    pulse_sample();
    n_cmp++;
    if (active_bank !== 1'b1) begin n_bad++; $display("FAIL held_swap_bank got %b want 1", active_bank); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (coeff !== e) begin n_bad++; $display("FAIL held_copy_coeff tap%0d got %h want %h", i, coeff, e); end
    end
    n = 1;
    while (commit_done !== 1'b1 && n < 32) begin
      n_cmp++;
      if (cfg_bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL held_copy_ready n%0d got %b want 0", n, cfg_bus.cfg_ready); end
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 5) begin n_bad++; $display("FAIL held_latency got %0d want 5", n); end
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL held_done_ready got %b want 1", cfg_bus.cfg_ready); end
    tick();
    cfg_bus.cfg_valid = 1'b0;
    sh[1] = 12'h055;
    rd_addr = 2'd1;
    #1;
    n_cmp++;
    if (coeff !== 12'hF00) begin n_bad++; $display("FAIL held_active_untouched got %h want f00", coeff); end
    commit_pulse();
    pulse_sample();
    n_cmp++;
    if (active_bank !== 1'b0) begin n_bad++; $display("FAIL held_swap2_bank got %b want 0", active_bank); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (coeff !== e) begin n_bad++; $display("FAIL held_write_coeff tap%0d got %h want %h", i, coeff, e); end
    end
    wait_done(1, n);
    tick();
  endtask

  task automatic test_err();
    int n;
    logic [11:0] e;
    drive_write(3'd5, 12'h7FF);
    n_cmp++;
    if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", cfg_err); end
    rd_addr = 2'd1;
    #1;
    n_cmp++;
    if (coeff !== 12'h055) begin n_bad++; $display("FAIL err_active got %h want 055", coeff); end
    tick();
    n_cmp++;
    if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", cfg_err); end
    commit_pulse();
    n_cmp++;
    if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", cfg_err); end
    pulse_sample();
    n_cmp++;
    if (active_bank !== 1'b1) begin n_bad++; $display("FAIL err_swap_bank got %b want 1", active_bank); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (coeff !== e) begin n_bad++; $display("FAIL err_dropped tap%0d got %h want %h", i, coeff, e); end
    end
    wait_done(1, n);
    n_cmp++;
    if (n !== 5) begin n_bad++; $display("FAIL err_latency got %0d want 5", n); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [11:0] rexp [4];
    logic saw_done;
    rexp[0] = 12'h400; rexp[1] = 12'h000; rexp[2] = 12'h000; rexp[3] = 12'h000;
    saw_done = 1'b0;
    drive_write(3'd0, 12'h333);
    commit_pulse();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rpend_ready got %b want 1", cfg_bus.cfg_ready); end
    n_cmp++;
    if (active_bank !== 1'b0) begin n_bad++; $display("FAIL rpend_bank got %b want 0", active_bank); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      n_cmp++;
      if (coeff !== rexp[i]) begin n_bad++; $display("FAIL rpend_coeff tap%0d got %h want %h", i, coeff, rexp[i]); end
    end
    drive_write(3'd3, 12'h321);
    commit_pulse();
    pulse_sample();
    exp_q.delete();
    n_cmp++;
    if (active_bank !== 1'b1) begin n_bad++; $display("FAIL rcopy_swap got %b want 1", active_bank); end
    if (commit_done === 1'b1) saw_done = 1'b1;
    tick();
    if (commit_done === 1'b1) saw_done = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if (active_bank !== 1'b0) begin n_bad++; $display("FAIL rcopy_bank got %b want 0", active_bank); end
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rcopy_ready got %b want 1", cfg_bus.cfg_ready); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      n_cmp++;
      if (coeff !== rexp[i]) begin n_bad++; $display("FAIL rcopy_coeff tap%0d got %h want %h", i, coeff, rexp[i]); end
    end
    for (int k = 0; k < 10; k++) begin
      if (commit_done === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rmid_no_done got %b want 0", saw_done); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst                = 1'b1;
    sample_done        = 1'b0;
    rd_addr            = 2'd0;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_addr   = 3'd0;
    cfg_bus.cfg_data   = 12'h000;
    cfg_bus.cfg_commit = 1'b0;
    test_reset();
    test_basic_commit();
    test_same_cycle_commit();
    test_held_write();
    test_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
